// File: rtl/down_count_timer_if.sv
// Bundles the down_count_timer control inputs and status outputs.
//   start        load load_val and (re)start counting
//   load_val     start value, also captured as the reload value
//   auto_reload  at the terminal step: 1 = reload and keep running, 0 = stop
//   pause        level; freezes count and prescaler while high
//   count        current count value
//   busy         timer is running or held
//   done         1-cycle pulse at the terminal count
// Modports: master drives the controls, slave is the timer itself.
interface down_count_timer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, auto_reload, pause,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, auto_reload, pause,
    output count, busy, done
  );
endinterface

// File: rtl/down_count_timer.sv
// Loadable down-counter timer with prescaler, pause and optional auto-reload.
// It is loaded with a value, decrements once per prescaled tick down to zero,
// then pulses done for one cycle. With auto-reload it restarts from the last
// loaded value, which makes it a periodic tick source.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous, active-low reset
//   bus  down_count_timer_if.slave (start, load_val, auto_reload, pause in;
//        count, busy, done out)
// Parameters:
//   WIDTH     width of load_val, count and the reload register
//   PRESCALE  clk cycles per count step, 1..256
module down_count_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  down_count_timer_if.slave     bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      presc  <= '0;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.start) begin
        // A start always reloads and restarts the prescaler, whatever the
        // state. Loading zero from IDLE is an immediate timeout; loading
        // zero while busy is an abort and stays silent.
        reload <= bus.load_val;
        presc  <= '0;
        if (bus.load_val != '0) begin
          count <= bus.load_val;
          state <= RUN;
        end else begin
          count <= '0;
          state <= IDLE;
          if (state == IDLE) done <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (bus.pause) begin
              state <= HOLD;
            end else if (presc == PS_LAST) begin
              presc <= '0;
              // count is never 0 in RUN, so 1 is the terminal value
              if (count == WIDTH'(1)) begin
                done <= 1'b1;
                if (bus.auto_reload) begin
                  count <= reload;
                end else begin
                  count <= '0;
                  state <= IDLE;
                end
              end else begin
                count <= count - WIDTH'(1);
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          HOLD: begin
            if (!bus.pause) state <= RUN;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count = count;
  assign bus.busy  = (state == RUN) || (state == HOLD);
  assign bus.done  = done;

endmodule

// File: tb/tb_down_count_timer.sv
// Drives two timers (PRESCALE 1 and 4) with the same stimulus and compares
// both against a cycle-level reference model built on elapsed-cycle counts.
module tb_down_count_timer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         pause = 1'b0;

  down_count_timer_if #(.WIDTH(W)) bus1 ();
  down_count_timer_if #(.WIDTH(W)) bus4 ();

  assign bus1.start = start;       assign bus4.start = start;
  assign bus1.load_val = load_val; assign bus4.load_val = load_val;
  assign bus1.auto_reload = auto_reload;
  assign bus4.auto_reload = auto_reload;
  assign bus1.pause = pause;       assign bus4.pause = pause;

  down_count_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  down_count_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks = 0;
  int failures = 0;

  // Reference model: a running timer has consumed el cycles of a
  // rel*P-cycle period, so its count is rel - el/P.
  int  pr[2] = '{1, 4};
  bit  m_act[2];
  bit  m_frz[2];
  bit  m_done[2];
  int  m_el[2];
  int  m_rel[2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (!rst) begin
        m_act[k] = 1'b0; m_frz[k] = 1'b0; m_el[k] = 0; m_rel[k] = 0;
      end else if (start) begin
        m_rel[k] = int'(load_val);
        m_el[k]  = 0;
        m_frz[k] = 1'b0;
        if (load_val != 0) begin
          m_act[k] = 1'b1;
        end else begin
          if (!m_act[k]) m_done[k] = 1'b1;
          m_act[k] = 1'b0;
        end
      end else if (m_act[k]) begin
        if (m_frz[k]) begin
          if (!pause) m_frz[k] = 1'b0;
        end else if (pause) begin
          m_frz[k] = 1'b1;
        end else begin
          m_el[k]++;
          if (m_el[k] == m_rel[k] * pr[k]) begin
            m_done[k] = 1'b1;
            m_el[k] = 0;
            if (!auto_reload) m_act[k] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    int ec;
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] oc;
      logic ob, od;
      oc = (k == 0) ? bus1.count : bus4.count;
      ob = (k == 0) ? bus1.busy  : bus4.busy;
      od = (k == 0) ? bus1.done  : bus4.done;
      ec = m_act[k] ? (m_rel[k] - m_el[k] / pr[k]) : 0;
      checks++;
      assert (oc === W'(ec)) else begin
        failures++;
        $error("FAIL count_p%0d t=%0t got %0d exp %0d", pr[k], $time, oc, ec);
      end
      checks++;
      assert (ob === m_act[k]) else begin
        failures++;
        $error("FAIL busy_p%0d t=%0t got %0b exp %0b", pr[k], $time, ob, m_act[k]);
      end
      checks++;
      assert (od === m_done[k]) else begin
        failures++;
        $error("FAIL done_p%0d t=%0t got %0b exp %0b", pr[k], $time, od, m_done[k]);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic do_start(input int lv, input bit ar);
    start = 1'b1; load_val = W'(lv); auto_reload = ar;
    tick(1);
    start = 1'b0;
  endtask

  task automatic lit_check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick(2);
    lit_check("reset_count", int'(bus1.count), 0);
    lit_check("reset_busy", int'(bus1.busy), 0);
    rst = 1'b1;
    tick(1);

    // Load 3, PRESCALE 1: 3,2,1,0 with done on 0
    do_start(3, 1'b0);
    lit_check("load3_count", int'(bus1.count), 3);
    tick(3);
    lit_check("term_count", int'(bus1.count), 0);
    lit_check("term_done", int'(bus1.done), 1);
    lit_check("term_busy", int'(bus1.busy), 0);
    tick(10);

    // Load 2: terminal 8 cycles after load on the PRESCALE 4 timer
    do_start(2, 1'b0);
    tick(7);
    lit_check("p4_pre_term", int'(bus4.count), 1);
    tick(1);
    lit_check("p4_term_done", int'(bus4.done), 1);
    tick(3);

    // Auto-reload period 5
    do_start(5, 1'b1);
    tick(22);
    lit_check("auto_busy", int'(bus1.busy), 1);
    auto_reload = 1'b0;
    tick(30);

    // Pause at count 4 for 3 cycles, then resume
    do_start(6, 1'b0);
    tick(2);
    lit_check("pre_pause", int'(bus1.count), 4);
    pause = 1'b1;
    tick(3);
    lit_check("paused", int'(bus1.count), 4);
    pause = 1'b0;
    tick(1);
    lit_check("resume_edge", int'(bus1.count), 4);
    tick(1);
    lit_check("resumed", int'(bus1.count), 3);
    tick(30);

    // Restart with 9 at count 2, then abort with 0 while busy
    do_start(4, 1'b0);
    tick(2);
    do_start(9, 1'b0);
    lit_check("restart9", int'(bus1.count), 9);
    tick(3);
    do_start(0, 1'b0);
    lit_check("abort_done", int'(bus1.done), 0);
    tick(2);

    // Start coinciding with the terminal step, and start with pause
    do_start(2, 1'b0);
    tick(1);
    pause = 1'b1;
    do_start(7, 1'b0);
    pause = 1'b0;
    lit_check("start_over_term", int'(bus1.done), 0);
    tick(40);

    // Reset mid-count, then zero-load from IDLE
    do_start(9, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    do_start(0, 1'b0);
    lit_check("zero_load_done", int'(bus1.done), 1);
    tick(2);

    // Maximum load value
    do_start(255, 1'b0);
    tick(260);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) != 0);
      start       = ($urandom_range(0, 19) == 0);
      load_val    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1))
                                                : W'($urandom_range(0, 12));
      auto_reload = $urandom_range(0, 1);
      pause       = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
